// File: rtl/fpu_frmt_pkg.sv
// Shared definitions for the FPU result formatting stage.
// Flag positions, field masks and the IEEE word packer.
package fpu_frmt_pkg;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;
  localparam int MAXW    = 64;

  function automatic logic [MAXW-1:0] ones(input int n);
    return (MAXW'(1) << n) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] exp_max(input int ew);
    return ones(ew);
  endfunction

  function automatic logic [MAXW-1:0] qnan_sgf(input int sw);
    return MAXW'(1) << (sw - 1);
  endfunction

  // Data follows inv > ovf > unf even when several flags are set.
  function automatic logic [MAXW-1:0] fmt_word(
    input int               ew,
    input int               sw,
    input logic             sign,
    input logic [MAXW-1:0]  exp,
    input logic [MAXW-1:0]  sgf,
    input logic [2:0]       flags
  );
    logic            s;
    logic [MAXW-1:0] e;
    logic [MAXW-1:0] m;
    s = sign;
    e = exp & ones(ew);
    m = sgf & ones(sw);
    priority case (1'b1)
      flags[FLG_INV]: begin
        s = 1'b0;
        e = exp_max(ew);
        m = qnan_sgf(sw);
      end
      flags[FLG_OVF]: begin
        e = exp_max(ew);
        m = '0;
      end
      flags[FLG_UNF]: begin
        e = '0;
        m = '0;
      end
      default: ;
    endcase
    return (MAXW'(s) << (ew + sw)) | (e << sw) | m;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready register slice.
// Output register plus one skid entry; ready_o is registered.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         out_v;
  logic         skid_v;
  logic [W-1:0] out_d;
  logic [W-1:0] skid_d;
  logic         in_fire;
  logic         load;

  assign in_fire = valid_i & ~skid_v;
  assign load    = ~out_v | ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_d  <= '0;
      skid_d <= '0;
    end else if (load) begin
      if (skid_v) begin
        out_d  <= skid_d;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= in_fire;
        if (in_fire) out_d <= data_i;
      end
    end else if (in_fire) begin
      skid_v <= 1'b1;
      skid_d <= data_i;
    end
  end

  assign ready_o = ~skid_v;
  assign valid_o = out_v;
  assign data_o  = out_d;

endmodule

// File: rtl/frmt_stage_pipe.sv
// Final add/sub formatting stage: IEEE packing, exception forcing,
// skid-buffered handshake, sticky flags and saturating result count.
module frmt_stage_pipe
  import fpu_frmt_pkg::*;
#(
  parameter int W    = 32,
  parameter int EW   = 8,
  parameter int SW   = 23,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            overflow_flag,
  input  logic            underflow_flag,
  input  logic            nan_flag,
  input  logic            sign_i,
  input  logic [EW-1:0]   exp_ieee_i,
  input  logic [SW-1:0]   sgf_ieee_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [W-1:0]    formatted_number,
  output logic [2:0]      flags_o,
  output logic [2:0]      sticky_o,
  input  logic            clr_sticky_i,
  output logic [CNTW-1:0] cnt_o
);

  if (W != 1 + EW + SW) begin : g_width_chk
    $fatal(1, "frmt_stage_pipe: W must equal 1+EW+SW");
  end

  logic [2:0]   flg;
  logic [W-1:0] word;
  logic [W+2:0] in_data;
  logic [W+2:0] out_data;
  logic         xfer;

  always_comb begin
    flg          = '0;
    flg[FLG_INV] = nan_flag;
    flg[FLG_OVF] = overflow_flag;
    flg[FLG_UNF] = underflow_flag;
  end

  assign word = W'(fmt_word(EW, SW, sign_i,
                            MAXW'(exp_ieee_i),
                            MAXW'(sgf_ieee_i), flg));

  assign in_data = {flg, word};

  skid_buf #(.W(W + 3)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (in_data),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_data)
  );

  assign formatted_number = out_data[W-1:0];
  assign flags_o          = out_data[W+2:W];
  assign xfer             = valid_o & ready_i;

  // A clear in the same cycle as a transfer keeps only the new flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_o <= '0;
      cnt_o    <= '0;
    end else begin
      if (xfer)
        sticky_o <= (clr_sticky_i ? 3'b000 : sticky_o) | flags_o;
      else if (clr_sticky_i)
        sticky_o <= '0;
      if (xfer && (cnt_o != {CNTW{1'b1}}))
        cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_frmt_stage_pipe.sv
// Bench for frmt_stage_pipe: single, double and 2-bit-counter instances
// checked against a queue-based reference model.
module tb_frmt_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        ovf = 1'b0;
  logic        unf = 1'b0;
  logic        nan = 1'b0;
  logic        sign = 1'b0;
  logic [7:0]  exp_s = '0;
  logic [22:0] sgf_s = '0;
  logic [10:0] exp_d = '0;
  logic [51:0] sgf_d = '0;
  logic        clr = 1'b0;

  logic        ready_o, valid_o;
  logic [31:0] word_o;
  logic [2:0]  flags_o, sticky_o;
  logic [15:0] cnt_o;

  logic        ready_d, valid_d;
  logic [63:0] word_d;
  logic [2:0]  flags_d, sticky_d;
  logic [15:0] cnt_d;

  logic        ready_c, valid_c;
  logic [31:0] word_c;
  logic [2:0]  flags_c, sticky_c;
  logic [1:0]  cnt_c;

  always #5 clk = ~clk;

  frmt_stage_pipe #(.W(32), .EW(8), .SW(23), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .overflow_flag(ovf), .underflow_flag(unf), .nan_flag(nan),
    .sign_i(sign), .exp_ieee_i(exp_s), .sgf_ieee_i(sgf_s),
    .valid_o(valid_o), .ready_i(ready_i), .formatted_number(word_o),
    .flags_o(flags_o), .sticky_o(sticky_o), .clr_sticky_i(clr),
    .cnt_o(cnt_o)
  );

  frmt_stage_pipe #(.W(64), .EW(11), .SW(52), .CNTW(16)) dut_d (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_d),
    .overflow_flag(ovf), .underflow_flag(unf), .nan_flag(nan),
    .sign_i(sign), .exp_ieee_i(exp_d), .sgf_ieee_i(sgf_d),
    .valid_o(valid_d), .ready_i(ready_i), .formatted_number(word_d),
    .flags_o(flags_d), .sticky_o(sticky_d), .clr_sticky_i(clr),
    .cnt_o(cnt_d)
  );

  frmt_stage_pipe #(.W(32), .EW(8), .SW(23), .CNTW(2)) dut_c (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_c),
    .overflow_flag(ovf), .underflow_flag(unf), .nan_flag(nan),
    .sign_i(sign), .exp_ieee_i(exp_s), .sgf_ieee_i(sgf_s),
    .valid_o(valid_c), .ready_i(ready_i), .formatted_number(word_c),
    .flags_o(flags_c), .sticky_o(sticky_c), .clr_sticky_i(clr),
    .cnt_o(cnt_c)
  );

  typedef struct {
    logic [31:0] w32;
    logic [63:0] w64;
    logic [2:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  m_sticky = '0;
  int          m_cnt = 0;
  int          m_cnt_c = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] ref32(logic s, logic [7:0] e,
                                        logic [22:0] m, logic n,
                                        logic o, logic u);
    if (n) return {1'b0, 8'hFF, 1'b1, 22'd0};
    if (o) return {s, 8'hFF, 23'd0};
    if (u) return {s, 31'd0};
    return {s, e, m};
  endfunction

  function automatic logic [63:0] ref64(logic s, logic [10:0] e,
                                        logic [51:0] m, logic n,
                                        logic o, logic u);
    if (n) return {1'b0, 11'h7FF, 1'b1, 51'd0};
    if (o) return {s, 11'h7FF, 52'd0};
    if (u) return {s, 63'd0};
    return {s, e, m};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(output bit acc);
    bit   xfer;
    ent_t e;
    acc   = rst && valid_i && (mq.size() < 2);
    xfer  = rst && (mq.size() > 0) && ready_i;
    e.w32 = ref32(sign, exp_s, sgf_s, nan, ovf, unf);
    e.w64 = ref64(sign, exp_d, sgf_d, nan, ovf, unf);
    e.f   = {nan, ovf, unf};
    @(posedge clk);
    #1;
    if (!rst) begin
      mq.delete();
      m_sticky = '0;
      m_cnt    = 0;
      m_cnt_c  = 0;
    end else begin
      if (xfer) begin
        m_sticky = (clr ? 3'b000 : m_sticky) | mq[0].f;
        m_cnt++;
        if (m_cnt_c < 3) m_cnt_c++;
        void'(mq.pop_front());
      end else if (clr) begin
        m_sticky = '0;
      end
      if (acc) mq.push_back(e);
    end
    chk("ready_o", ready_o, mq.size() < 2);
    chk("valid_o", valid_o, mq.size() > 0);
    chk("valid_dbl", valid_d, mq.size() > 0);
    chk("ready_dbl", ready_d, mq.size() < 2);
    if (mq.size() > 0) begin
      chk("word", word_o, mq[0].w32);
      chk("flags", flags_o, mq[0].f);
      chk("word_dbl", word_d, mq[0].w64);
    end
    chk("sticky", sticky_o, m_sticky);
    chk("cnt", cnt_o, m_cnt);
    chk("cnt_sat", cnt_c, m_cnt_c);
  endtask

  task automatic set_in(bit v, bit s, logic [7:0] e, logic [22:0] m,
                        bit n, bit o, bit u);
    valid_i = v;
    sign    = s;
    exp_s   = e;
    sgf_s   = m;
    exp_d   = {e[7], 3'b000, e[6:0]};
    sgf_d   = {m, 29'h1ABCDEF};
    nan     = n;
    ovf     = o;
    unf     = u;
  endtask

  initial begin
    bit acc;
    int n;
    int k;
    bit saw_low;

    rst = 1'b0;
    cycle(acc);
    cycle(acc);
    chk("rst_word", word_o, 32'h0);
    chk("rst_flags", flags_o, 3'b000);
    rst = 1'b1;

    // normal word
    ready_i = 1'b1;
    set_in(1, 1, 8'h80, 23'h400000, 0, 0, 0);
    cycle(acc);
    chk("t1_word", word_o, 32'hC0400000);
    chk("t1_flags", flags_o, 3'b000);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle(acc);
    chk("t1_cnt", cnt_o, 16'd1);

    // overflow then underflow, sign kept
    set_in(1, 1, 8'h12, 23'h345, 0, 1, 0);
    cycle(acc);
    chk("t2_inf", word_o, 32'hFF800000);
    chk("t2_inf_dbl", word_d, 64'hFFF0000000000000);
    chk("t2_inf_flags", flags_o, 3'b010);
    set_in(1, 1, 8'h12, 23'h345, 0, 0, 1);
    cycle(acc);
    chk("t2_zero", word_o, 32'h80000000);
    chk("t2_zero_dbl", word_d, 64'h8000000000000000);
    chk("t2_zero_flags", flags_o, 3'b001);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle(acc);
    clr = 1'b1;
    cycle(acc);
    clr = 1'b0;

    // nan with overflow
    set_in(1, 1, 8'h55, 23'h1, 1, 1, 0);
    cycle(acc);
    chk("t3_qnan", word_o, 32'h7FC00000);
    chk("t3_qnan_dbl", word_d, 64'h7FF8000000000000);
    chk("t3_flags", flags_o, 3'b110);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle(acc);
    chk("t3_sticky", sticky_o, 3'b110);

    // 6-word stream with a 3-cycle stall
    n = 0;
    k = 0;
    saw_low = 0;
    while (n < 6 && k < 20) begin
      set_in(1, 0, 8'h40 + 8'(n), 23'(n + 1), 0, 0, 0);
      ready_i = !(k >= 2 && k <= 4);
      cycle(acc);
      if (!ready_o) saw_low = 1;
      if (acc) n++;
      k++;
    end
    chk("t4_accepted", n, 6);
    chk("t4_ready_low", saw_low, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    ready_i = 1'b1;
    k = 0;
    while (mq.size() > 0 && k < 10) begin
      cycle(acc);
      k++;
    end
    chk("t4_drained", mq.size(), 0);
    chk("t6_cnt_sat", cnt_c, 2'd3);

    // clear concurrent with an overflow transfer
    set_in(1, 0, 8'h01, 23'h2, 0, 1, 0);
    cycle(acc);
    set_in(0, 0, 0, 0, 0, 0, 0);
    clr = 1'b1;
    cycle(acc);
    clr = 1'b0;
    chk("t5_sticky", sticky_o, 3'b010);

    // reset while the skid entry is full
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 8'h7F, 23'(i), 0, 0, 0);
      cycle(acc);
    end
    chk("t5_full", ready_o, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle(acc);
    chk("t5_rst_valid", valid_o, 1'b0);
    chk("t5_rst_ready", ready_o, 1'b1);
    chk("t5_rst_cnt", cnt_o, 16'd0);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, 1'($urandom),
             8'($urandom), 23'($urandom),
             ($urandom % 8) == 0, ($urandom % 8) == 0,
             ($urandom % 8) == 0);
      exp_d   = 11'($urandom);
      sgf_d   = {20'($urandom), 32'($urandom)};
      ready_i = ($urandom % 3) != 0;
      clr     = ($urandom % 16) == 0;
      cycle(acc);
    end
    chk("rand_cnt_sat", cnt_c, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
